// File: rtl/des_pkg.sv
// DES round sequencer shared types and constants.
// Also holds the S-box tables and their lookup helper.
package des_pkg;

  localparam int NUM_ROUNDS = 16;
  localparam int HALF_W     = 32;
  localparam int SUBKEY_W   = 48;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // One 256-bit word per box: nibble 0 (row 0, col 0) at the MSB.
  localparam logic [0:7][255:0] SBOX = {
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  function automatic logic [3:0] sbox_lookup(
    input logic [255:0] tab,
    input logic [5:0]   b
  );
    logic [255:0] t;
    t = tab << {b[5], b[0], b[4:1], 2'b00};
    return t[255:252];
  endfunction

endpackage

// File: rtl/des_round_sequencer_if.sv
// Block-in / result-out handshake bundle
// for the DES round sequencer.
interface des_round_sequencer_if;
  import des_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [HALF_W-1:0] in_left;
  logic [HALF_W-1:0] in_right;
  logic              decrypt;
  logic              out_valid;
  logic              out_ready;
  logic [HALF_W-1:0] out_left;
  logic [HALF_W-1:0] out_right;

  modport slave (
    input  in_valid, in_left, in_right, decrypt, out_ready,
    output in_ready, out_valid, out_left, out_right
  );

  modport master (
    output in_valid, in_left, in_right, decrypt, out_ready,
    input  in_ready, out_valid, out_left, out_right
  );

endinterface

// File: rtl/des_feistel.sv
// DES f-function: expand, key mix, S-boxes, P permutation.
// Purely combinational; DES bit 1 is the MSB of each vector.
module des_feistel
  import des_pkg::*;
(
  input  logic [HALF_W-1:0]   r,
  input  logic [SUBKEY_W-1:0] k,
  output logic [HALF_W-1:0]   f
);

  logic [SUBKEY_W-1:0] e;
  logic [SUBKEY_W-1:0] x;
  logic [HALF_W-1:0]   s;

  assign e = {
    r[0], r[31:27],
    r[28:23], r[24:19],
    r[20:15], r[16:11],
    r[12:7], r[8:3],
    r[4:0], r[31]
  };

  assign x = e ^ k;

  for (genvar i = 0; i < 8; i++) begin : g_sbox
    assign s[31-4*i -: 4] = sbox_lookup(SBOX[i], x[47-6*i -: 6]);
  end

  assign f = {
    s[16], s[25], s[12], s[11],
    s[3],  s[20], s[4],  s[15],
    s[31], s[17], s[9],  s[6],
    s[27], s[14], s[1],  s[22],
    s[30], s[24], s[8],  s[18],
    s[0],  s[5],  s[29], s[23],
    s[13], s[19], s[2],  s[26],
    s[10], s[21], s[28], s[7]
  };

endmodule

// File: rtl/des_round_sequencer.sv
// Iterative 16-round DES Feistel sequencer, one round per clock.
// Subkeys are fetched from an external store via key_idx.
module des_round_sequencer
  import des_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  des_round_sequencer_if.slave  bus,
  input  logic                  flush,
  output logic [3:0]            key_idx,
  input  logic [SUBKEY_W-1:0]   round_key,
  output logic                  busy
);

  state_e            st;
  logic [HALF_W-1:0] l_q;
  logic [HALF_W-1:0] r_q;
  logic [HALF_W-1:0] f_out;
  logic [3:0]        cnt;
  logic              mode;
  logic              accept;
  logic              last;

  // flush wins over the input handshake, so never offer ready then
  assign bus.in_ready  = (st == IDLE) && !rst && !flush;
  assign accept        = bus.in_valid && bus.in_ready;
  assign last          = cnt == 4'(NUM_ROUNDS - 1);

  assign bus.out_valid = st == DONE;
  assign bus.out_left  = (st == DONE) ? r_q : '0;
  assign bus.out_right = (st == DONE) ? l_q : '0;
  assign busy          = st == RUN;

  assign key_idx = (st != RUN) ? 4'h0 :
                   mode ? 4'(NUM_ROUNDS - 1) - cnt : cnt;

  des_feistel u_feistel (
    .r (r_q),
    .k (round_key),
    .f (f_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= IDLE;
      l_q  <= '0;
      r_q  <= '0;
      cnt  <= '0;
      mode <= 1'b0;
    end else if (flush) begin
      st  <= IDLE;
      l_q <= '0;
      r_q <= '0;
      cnt <= '0;
    end else begin
      unique case (st)
        IDLE: begin
          if (accept) begin
            l_q  <= bus.in_left;
            r_q  <= bus.in_right;
            mode <= bus.decrypt;
            cnt  <= '0;
            st   <= RUN;
          end
        end
        RUN: begin
          l_q <= r_q;
          r_q <= l_q ^ f_out;
          // cnt parks at its terminal value instead of wrapping
          if (last) st <= DONE;
          else      cnt <= cnt + 4'd1;
        end
        DONE: begin
          if (bus.out_ready) st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_round_sequencer.sv
// Directed bench for des_round_sequencer using the
// classic 133457799BBCDFF1 key schedule.
module tb_des_round_sequencer;
  import des_pkg::*;

  localparam logic [63:0] PT = 64'hCC00CCFF_F0AAF0AA;
  localparam logic [63:0] CT = 64'h0A4CD995_43423234;
  localparam logic [63:0] ENC_SEQ = 64'h0123456789ABCDEF;
  localparam logic [63:0] DEC_SEQ = 64'hFEDCBA9876543210;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  key_idx;
  logic [47:0] round_key;
  logic        busy;
  logic [47:0] ks [16];
  int          checks = 0;
  int          errors = 0;

  des_round_sequencer_if bus();

  des_round_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .flush     (flush),
    .key_idx   (key_idx),
    .round_key (round_key),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  assign round_key = ks[key_idx];

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [63:0] blk, input logic dec);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    {bus.in_left, bus.in_right} = blk;
    bus.decrypt = dec;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    {bus.in_left, bus.in_right} = ~blk;
    bus.decrypt = ~dec;
  endtask

  task automatic collect(
    input logic [63:0] exp,
    input logic        dec,
    input string       tag
  );
    logic [63:0] seq;
    int lat;
    seq = '0;
    lat = 99;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = n;
        break;
      end
      if (n < 16) seq = {seq[59:0], key_idx};
    end
    chk({tag, "_latency"}, 64'(lat), 64'd16);
    chk({tag, "_keyseq"}, seq, dec ? DEC_SEQ : ENC_SEQ);
    chk({tag, "_out"}, {bus.out_left, bus.out_right}, exp);
  endtask

  task automatic release_out(input string tag);
    chk({tag, "_done_rdy"}, 64'(bus.in_ready), 64'd0);
    chk({tag, "_done_kidx"}, 64'(key_idx), 64'd0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_vld"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_idle_rdy"}, 64'(bus.in_ready), 64'd1);
  endtask

  task automatic b2b();
    logic [63:0] bin [3];
    logic [63:0] bexp [3];
    logic        bdec [3];
    int          acc [3];
    int          nacc;
    int          nout;
    logic        took;
    bin  = '{PT, CT, PT};
    bexp = '{CT, PT, CT};
    bdec = '{1'b0, 1'b1, 1'b0};
    acc  = '{0, 0, 0};
    nacc = 0;
    nout = 0;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    {bus.in_left, bus.in_right} = bin[0];
    bus.decrypt = bdec[0];
    for (int c = 0; c < 90 && nout < 3; c++) begin
      if (bus.out_valid) begin
        chk($sformatf("b2b_out%0d", nout),
            {bus.out_left, bus.out_right}, bexp[nout]);
        nout++;
      end
      took = bus.in_valid && bus.in_ready;
      if (took && nacc < 3) begin
        acc[nacc] = c;
        nacc++;
      end
      @(posedge clk);
      #1;
      if (took) begin
        if (nacc < 3) begin
          {bus.in_left, bus.in_right} = bin[nacc];
          bus.decrypt = bdec[nacc];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk("b2b_results", 64'(nout), 64'd3);
    chk("b2b_gap01", 64'(acc[1] - acc[0]), 64'd18);
    chk("b2b_gap12", 64'(acc[2] - acc[1]), 64'd18);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic stable;
    logic seen;
    logic found;
    ks = '{
      48'h1B02EFFC7072, 48'h79AED9DBC9E5,
      48'h55FC8A42CF99, 48'h72ADD6DB351D,
      48'h7CEC07EB53A8, 48'h63A53E507B2F,
      48'hEC84B7F618BC, 48'hF78A3AC13BFB,
      48'hE0DBEBEDE781, 48'hB1F347BA464F,
      48'h215FD3DED386, 48'h7571F59467E9,
      48'h97C5D1FABA41, 48'h5F43B7F2E73A,
      48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };
    bus.in_valid  = 1'b0;
    bus.in_left   = '0;
    bus.in_right  = '0;
    bus.decrypt   = 1'b0;
    bus.out_ready = 1'b0;

    #1 rst = 1'b1;
    #2;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_key_idx", 64'(key_idx), 64'd0);
    chk("rst_out", {bus.out_left, bus.out_right}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(bus.in_ready), 64'd1);

    send(PT, 1'b0);
    collect(CT, 1'b0, "enc");
    release_out("enc");

    send(CT, 1'b1);
    collect(PT, 1'b1, "dec");
    release_out("dec");

    send(PT, 1'b0);
    collect(CT, 1'b0, "bp");
    bus.in_valid = 1'b1;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if ({bus.out_left, bus.out_right} !== CT || !bus.out_valid ||
          bus.in_ready || busy)
        stable = 1'b0;
    end
    chk("bp_stable", 64'(stable), 64'd1);
    bus.in_valid = 1'b0;
    release_out("bp");

    send(PT, 1'b0);
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (busy && key_idx == 4'd7) begin
        found = 1'b1;
        break;
      end
    end
    chk("flush_cnt7", 64'(found), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_rdy", 64'(bus.in_ready), 64'd1);
    chk("flush_busy", 64'(busy), 64'd0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("flush_no_valid", 64'(seen), 64'd0);
    send(PT, 1'b0);
    collect(CT, 1'b0, "flush_enc");
    release_out("flush_enc");

    send(PT, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("arst_key_idx", 64'(key_idx), 64'd0);
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("arst_idle_rdy", 64'(bus.in_ready), 64'd1);
    send(PT, 1'b0);
    collect(CT, 1'b0, "arst_enc");
    release_out("arst_enc");

    b2b();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/des_round_sequencer.md
DES_ROUND_SEQUENCER -- requirements
Module: des_round_sequencer

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  input block offered.
REQ-005 in_ready  output  1  block accepted on in_valid&&in_ready.
REQ-006 in_left / in_right  input  32 each  post-IP halves L0 / R0.
REQ-007 decrypt  input  1  0 = encrypt key order, 1 = decrypt; sampled at acceptance.
REQ-008 flush  input  1  synchronous abort to IDLE.
REQ-009 key_idx  output  4  round-key index to the external key store.
REQ-010 round_key  input  48  subkey for key_idx; asynchronous (same-cycle) read.
REQ-011 out_valid  output  1  result held valid.
REQ-012 out_ready  input  1  result consumed on out_valid&&out_ready.
REQ-013 out_left / out_right  output  32 each  pre-FP output, R16 / L16.
REQ-014 busy  output  1  high in RUN.

Function
REQ-015 SHALL use an FSM with states IDLE, RUN and DONE.
REQ-016 IDLE: in_ready=1; on accept, latch L<=in_left, R<=in_right, mode<=decrypt, cnt<=0, go to RUN.
REQ-017 RUN: key_idx = mode ? 15-cnt : cnt; each edge L<=R, R<=L^f(R,round_key), cnt<=cnt+1.
REQ-018 RUN with cnt==15: perform the final round, then go to DONE; exactly 16 rounds per block.
REQ-019 DONE: out_valid=1, out_left=R, out_right=L (undo last swap); values stable until handshake.
REQ-020 DONE with out_ready=1: go to IDLE; in_ready first rises the following cycle.
REQ-021 Latency: out_valid rises 16 clock edges after the acceptance edge; max throughput 1 block per 18 cycles.
REQ-022 in_ready and out_valid SHALL be low in RUN; in_valid is ignored outside IDLE.
REQ-023 key_idx SHALL be 0 in IDLE and DONE; round_key is ignored outside RUN.
REQ-024 flush SHALL move any state to IDLE next edge, clear L, R and cnt, and take priority over all handshakes.
REQ-025 4-bit cnt SHALL never wrap; cnt==15 is terminal in RUN.
REQ-026 in_left, in_right and decrypt changes after acceptance SHALL NOT affect the block in flight.

Reset
REQ-027 rst SHALL force state=IDLE, L=R=0, cnt=0, mode=0 immediately, independent of clk.
REQ-028 Outputs during reset: in_ready=0, out_valid=0, busy=0, key_idx=0, out_left=out_right=0.
REQ-029 rst asserted mid-RUN or in DONE SHALL discard the block; after deassertion the first cycle is IDLE with in_ready=1.

Structure
REQ-030 Package des_pkg SHALL hold the state enum (IDLE, RUN, DONE), NUM_ROUNDS=16, and width constants HALF_W=32, SUBKEY_W=48.
REQ-031 des_feistel SHALL be instantiated as the single sub-module, computing f from R and round_key.
REQ-032 The block SHALL contain no IP/FP, no key schedule and no key storage; subkeys come via key_idx/round_key.

Verification
REQ-033 Encrypt: key store K1..K16 of key 133457799BBCDFF1 (K1=1B02EFFC7072), in=CC00CCFF/F0AAF0AA, decrypt=0 -> out=0A4CD995/43423234 after 16 edges.
REQ-034 Decrypt: same keys, in=0A4CD995/43423234, decrypt=1 -> key_idx sequence 15..0, out=CC00CCFF/F0AAF0AA.
REQ-035 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out stays stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-036 flush at cnt=7 -> IDLE next edge, out_valid never asserted; new block then encrypts to the REQ-033 value.
REQ-037 Async rst pulse between edges mid-RUN -> outputs reset immediately; subsequent encrypt correct.
REQ-038 Back-to-back: in_valid held high for 3 blocks -> accepts spaced 18 cycles apart, results in order.
